// File: rtl/acc_vec_engine.sv
// acc_vec_engine: streams byte vectors A and B through an 8-bit ALU
// and writes the results to a result memory, one element per cycle.
module acc_vec_engine #(
  parameter int N_BYTES = 1024,
  parameter int IDX_W   = 10
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             start,
  input  logic [IDX_W:0]   len,
  input  logic [1:0]       op,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [7:0]       a_rd_data,
  input  logic [7:0]       b_rd_data,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(N_BYTES);
  localparam logic [IDX_W:0] ONE     = (IDX_W+1)'(1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W:0]   len_q;
  logic [1:0]       op_q;
  logic [IDX_W-1:0] idx_q;
  logic             p_vld;
  logic [IDX_W-1:0] p_addr;
  logic [IDX_W:0]   last;
  logic             issue_last;
  logic             write_last;
  logic [8:0]       sum;
  logic [7:0]       prod;
  logic [7:0]       res;

  assign last       = len_q - ONE;
  assign issue_last = rd_en && ({1'b0, idx_q} == last);
  assign write_last = wr_en && ({1'b0, wr_addr} == last);

  assign rd_en   = (state_q == RUN);
  assign rd_addr = idx_q;
  assign busy    = (state_q == RUN) || (state_q == FLUSH);
  assign done    = (state_q == DONE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue_last) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (write_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum  = {1'b0, a_rd_data} + {1'b0, b_rd_data};
    prod = a_rd_data * b_rd_data;
    res  = sum[7:0];
    unique case (op_q)
      2'b00: res = sum[7:0];
      2'b01: res = a_rd_data - b_rd_data;
      2'b10: res = prod;
      2'b11: res = sum[8] ? 8'hFF : sum[7:0];
      default: res = sum[7:0];
    endcase
  end

  // Index counter holds on the last element so it can never wrap.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      len_q   <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      p_vld   <= 1'b0;
      p_addr  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        len_q <= (len > MAX_LEN) ? MAX_LEN : len;
        op_q  <= op;
      end
      if (rd_en && !issue_last) begin
        idx_q <= idx_q + IDX_W'(1);
      end else if (state_q != RUN) begin
        idx_q <= '0;
      end
      p_vld  <= rd_en;
      p_addr <= idx_q;
      wr_en  <= p_vld;
      if (p_vld) begin
        wr_addr <= p_addr;
        wr_data <= res;
      end
    end
  end

endmodule

// File: tb/tb_acc_vec_engine.sv
// tb_acc_vec_engine: random and directed vector runs against a
// behavioural element-wise model with a write scoreboard.
module tb_acc_vec_engine;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic [10:0] len = '0;
  logic [1:0]  op = '0;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [7:0]  a_rd_data = '0;
  logic [7:0]  b_rd_data = '0;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;

  acc_vec_engine #(.N_BYTES(1024), .IDX_W(10)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .start     (start),
    .len       (len),
    .op        (op),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .a_rd_data (a_rd_data),
    .b_rd_data (b_rd_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 HCLK = ~HCLK;

  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];
  logic [7:0] got   [1024];
  logic [7:0] exp_q [1024];
  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic       rd_p1 = 1'b0;
  logic       rd_p2 = 1'b0;
  logic [9:0] ra_p1 = '0;
  logic [9:0] ra_p2 = '0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
               $time);
    end
  endtask

  function automatic logic [7:0] ref_op(input int o, input int a,
                                        input int b);
    int r;
    case (o)
      0: r = (a + b) % 256;
      1: r = (a - b + 256) % 256;
      2: r = (a * b) % 256;
      default: r = (a + b > 255) ? 255 : a + b;
    endcase
    return 8'(r);
  endfunction

  // Memory model: registered read, data valid the cycle after rd_en.
  always @(posedge HCLK) begin
    a_rd_data <= rd_en ? mem_a[rd_addr] : 8'($urandom);
    b_rd_data <= rd_en ? mem_b[rd_addr] : 8'($urandom);
  end

  always @(negedge HCLK) begin
    chk("busy_done_excl", {63'd0, busy & done}, 64'd0);
    if (wr_en) begin
      chk("wr_addr_seq", 64'(wr_addr), 64'(wr_cnt));
      chk("wr_latency", {53'd0, rd_p2, ra_p2}, {53'd0, 1'b1, wr_addr});
      chk("wr_while_busy", 64'(busy), 64'd1);
      if (wr_cnt < 1024) got[wr_cnt] = wr_data;
      wr_cnt++;
    end
    if (rd_en) begin
      chk("rd_addr_seq", 64'(rd_addr), 64'(rd_cnt));
      rd_cnt++;
    end
    if (!HRESETn) begin
      rd_p1 = 1'b0;
      rd_p2 = 1'b0;
    end else begin
      rd_p2 = rd_p1;
      ra_p2 = ra_p1;
      rd_p1 = rd_en;
      ra_p1 = rd_addr;
    end
  end

  task automatic fill_rand();
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
  endtask

  // Drives a request and builds the expected result vector.
  task automatic begin_op(input int n, input int o);
    int ne;
    ne = (n > 1024) ? 1024 : n;
    wr_cnt = 0;
    rd_cnt = 0;
    len = 11'(n);
    op = 2'(o);
    start = 1'b1;
    for (int i = 0; i < ne; i++)
      exp_q[i] = ref_op(o, int'(mem_a[i]), int'(mem_b[i]));
  endtask

  task automatic wait_op(input int n, input bit disturb);
    int ne;
    int k;
    ne = (n > 1024) ? 1024 : n;
    @(negedge HCLK);
    if (ne == 0) begin
      chk("zero_len_done", 64'(done), 64'd1);
      chk("zero_len_no_rd", 64'(rd_en), 64'd0);
    end else begin
      chk("run_busy", 64'(busy), 64'd1);
    end
    k = 0;
    while (!done && k < 3000) begin
      @(negedge HCLK);
      k++;
      if (disturb && k == 5) begin
        len = 11'($urandom_range(1, 2047));
        op = ~op;
      end
    end
    chk("done_timeout", 64'(k < 3000), 64'd1);
    chk("n_writes", 64'(wr_cnt), 64'(ne));
    chk("n_reads", 64'(rd_cnt), 64'(ne));
    for (int i = 0; i < ne; i++)
      chk("wr_data", 64'(got[i]), 64'(exp_q[i]));
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk("done_hold", 64'(done), 64'd1);
      chk("no_retrigger", {62'd0, rd_en, busy}, 64'd0);
    end
    chk("writes_after_done", 64'(wr_cnt), 64'(ne));
    start = 1'b0;
    @(negedge HCLK);
    chk("done_clear", {62'd0, done, busy}, 64'd0);
  endtask

  task automatic run_op(input int n, input int o, input bit disturb);
    @(negedge HCLK);
    begin_op(n, o);
    wait_op(n, disturb);
  endtask

  initial begin
    int k;
    int snap;
    fill_rand();
    #12;
    chk("reset_outs",
        {27'd0, busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data},
        64'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 8'(i);
      mem_b[i] = 8'h10;
    end
    run_op(8, 0, 1'b0);
    chk("dir_add_first", 64'(got[0]), 64'h10);
    chk("dir_add_last", 64'(got[7]), 64'h17);

    mem_a[0] = 8'hF0; mem_b[0] = 8'h20;
    run_op(1, 3, 1'b0);
    chk("dir_sat", 64'(got[0]), 64'hFF);
    mem_a[0] = 8'h05; mem_b[0] = 8'h07;
    run_op(1, 1, 1'b0);
    chk("dir_sub", 64'(got[0]), 64'hFE);
    mem_a[0] = 8'h13; mem_b[0] = 8'h11;
    run_op(1, 2, 1'b0);
    chk("dir_mul", 64'(got[0]), 64'h43);

    run_op(0, 0, 1'b0);

    fill_rand();
    run_op(16, int'($urandom_range(0, 3)), 1'b1);

    for (int t = 0; t < 20; t++) begin
      fill_rand();
      run_op(int'($urandom_range(1, 64)), int'($urandom_range(0, 3)),
             1'b0);
    end

    fill_rand();
    run_op(1024, 0, 1'b0);
    chk("full_last_idx", 64'(wr_cnt - 1), 64'd1023);
    run_op(1500, 3, 1'b0);

    // Abort a full-length run partway, then restart from reset release.
    fill_rand();
    @(negedge HCLK);
    begin_op(1024, 0);
    k = 0;
    while (rd_cnt < 500 && k < 2000) begin
      @(negedge HCLK);
      k++;
    end
    chk("abort_reach", 64'(k < 2000), 64'd1);
    #2 HRESETn = 1'b0;
    #1;
    chk("abort_outs",
        {27'd0, busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data},
        64'd0);
    snap = wr_cnt;
    repeat (3) @(negedge HCLK);
    chk("abort_no_wr", 64'(wr_cnt), 64'(snap));
    begin_op(1024, 2);
    HRESETn = 1'b1;
    wait_op(1024, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
